// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M muldiv unit.
// Divider support is selected by the MULDIV_DIV_EN macro.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [XLEN-1:0] DIV0_QUOT = '1;
  localparam logic [XLEN-1:0] OVF_QUOT  = 32'h8000_0000;
  localparam logic [XLEN-1:0] OVF_REM   = '0;
  localparam logic [XLEN-1:0] MIN_INT   = 32'h8000_0000;

  function automatic logic a_signed(input op_e o);
    return o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(input op_e o);
    return o inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: conditional two's-complement negate.
// Used both for operand magnitudes and for result sign restore.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? -val : val;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle.
// Divider datapath compiled only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  input  logic [4:0]      addrD_in,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] dataD,
  output logic [4:0]      addrD,
  output logic            RWen
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [4:0]        cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_nxt, prod;
  logic [XLEN-1:0]   opa_q, opb_q, opb_nxt;
  logic              sa_q, sb_q, wen_q;
  logic [XLEN-1:0]   dat_q;
  logic [4:0]        adr_q;
  logic              accept, last;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b, ld_a, ld_b;
  logic              sp_hit, sp_wen;
  logic [XLEN-1:0]   sp_val, result;
  logic [XLEN:0]     sum;

  assign busy   = state_q == BUSY;
  assign ready  = !busy;
  assign done   = state_q == DONE;
  assign RWen   = done && wen_q;
  assign dataD  = dat_q;
  assign addrD  = adr_q;
  assign accept = start && ready;
  assign last   = cnt_q == 5'd31;

  assign neg_a = a_signed(op_e'(op)) && dataA[XLEN-1];
  assign neg_b = b_signed(op_e'(op)) && dataB[XLEN-1];

  muldiv_signfix #(.W(XLEN)) u_fix_a (
    .val (dataA),
    .neg (neg_a),
    .res (mag_a)
  );

  muldiv_signfix #(.W(XLEN)) u_fix_b (
    .val (dataB),
    .neg (neg_b),
    .res (mag_b)
  );

  muldiv_signfix #(.W(2*XLEN)) u_fix_p (
    .val (acc_nxt),
    .neg (sa_q ^ sb_q),
    .res (prod)
  );

  // shift-add: high half accumulates, low half shifts out to the right
  assign sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
             + (opb_q[0] ? {1'b0, opa_q} : '0);

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] quot, rem;
  logic            div_zero, div_ovf;

  // restoring step: acc = {remainder, quotient}, opb feeds dividend bits
  assign trial = {acc_q[2*XLEN-1:XLEN], opb_q[XLEN-1]}
               - {1'b0, opa_q};

  assign acc_nxt = !op_q[2] ? {sum, acc_q[XLEN-1:1]}
                 : !trial[XLEN]
                   ? {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                   : {acc_q[2*XLEN-2:XLEN], opb_q[XLEN-1],
                      acc_q[XLEN-2:0], 1'b0};

  assign opb_nxt = op_q[2] ? opb_q << 1 : opb_q >> 1;

  muldiv_signfix #(.W(XLEN)) u_fix_q (
    .val (acc_nxt[XLEN-1:0]),
    .neg (sa_q ^ sb_q),
    .res (quot)
  );

  muldiv_signfix #(.W(XLEN)) u_fix_r (
    .val (acc_nxt[2*XLEN-1:XLEN]),
    .neg (sa_q),
    .res (rem)
  );

  assign result = op_q[2] ? (op_q[1] ? rem : quot)
                : op_q == OP_MUL ? prod[XLEN-1:0]
                : prod[2*XLEN-1:XLEN];

  assign div_zero = op[2] && dataB == '0;
  assign div_ovf  = op[2] && !op[0]
                 && dataA == MIN_INT && dataB == '1;
  assign sp_hit   = div_zero || div_ovf;
  assign sp_val   = div_zero ? (op[1] ? dataA : DIV0_QUOT)
                             : (op[1] ? OVF_REM : OVF_QUOT);
  assign sp_wen   = addrD_in != '0;
  assign ld_a     = op[2] ? mag_b : mag_a;
  assign ld_b     = op[2] ? mag_a : mag_b;
`else
  logic unused_lsb;

  assign acc_nxt    = {sum, acc_q[XLEN-1:1]};
  assign opb_nxt    = opb_q >> 1;
  assign result     = op_q == OP_MUL ? prod[XLEN-1:0]
                    : prod[2*XLEN-1:XLEN];
  assign sp_hit     = op[2];
  assign sp_val     = '0;
  assign sp_wen     = 1'b0;
  assign ld_a       = mag_a;
  assign ld_b       = mag_b;
  assign unused_lsb = acc_q[0];
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = accept ? (sp_hit ? DONE : BUSY) : IDLE;
      BUSY:       if (last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      wen_q   <= 1'b0;
      dat_q   <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_e'(op);
        adr_q <= addrD_in;
        sa_q  <= neg_a;
        sb_q  <= neg_b;
        opa_q <= ld_a;
        opb_q <= ld_b;
        acc_q <= '0;
        cnt_q <= '0;
        wen_q <= sp_hit ? sp_wen : (addrD_in != '0);
        if (sp_hit) dat_q <= sp_val;
      end else if (busy) begin
        acc_q <= acc_nxt;
        opb_q <= opb_nxt;
        cnt_q <= cnt_q + 5'd1;
        if (last) dat_q <= result;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit
// against an arithmetic reference model and expected-result queue.
module tb_muldiv_unit;

  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] dataA, dataB, dataD;
  logic [4:0]  addrD_in, addrD;
  logic        ready, busy, done, RWen;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_done = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic        w;
    int          due;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dataA    (dataA),
    .dataB    (dataB),
    .addrD_in (addrD_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .dataD    (dataD),
    .addrD    (addrD),
    .RWen     (RWen)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic is_fast(input logic [2:0] o,
                                   input logic [31:0] a, b);
`ifdef MULDIV_DIV_EN
    return o[2] && (b == 0 ||
      (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
    return o[2];
`endif
  endfunction

  function automatic logic ref_wen(input logic [2:0] o,
                                   input logic [4:0] ad);
`ifndef MULDIV_DIV_EN
    if (o[2]) return 1'b0;
`endif
    return ad != 0;
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] o,
                                          input logic [31:0] a, b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] ua, uu;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    ub = {32'b0, b};
    ua = {32'b0, a};
`ifndef MULDIV_DIV_EN
    if (o[2]) return 32'h0;
`endif
    case (o)
      MUL:    begin p = sa * sb; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin uu = ua * {32'b0, b}; return uu[63:32]; end
      DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      DIVU:   begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      REM:    begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // per-cycle comparison against the expected-result queue
  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        tests++;
        fails++;
        $display("FAIL done_missing: got none expected due %0d (cycle %0d)",
                 q[0].due, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        check("done", 32'(done), 32'd1);
        check("dataD", dataD, q[0].d);
        check("addrD", 32'(addrD), 32'(q[0].a));
        check("RWen", 32'(RWen), 32'(q[0].w));
        check("busy_done", 32'(busy), 32'd0);
        void'(q.pop_front());
      end else begin
        check("done_idle", 32'(done), 32'd0);
        check("RWen_idle", 32'(RWen), 32'd0);
        check("busy", 32'(busy), 32'(q.size() > 0));
      end
      check("ready", 32'(ready), 32'(!busy));
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, b,
                       input logic [4:0] ad, output int n);
    exp_t e;
    int w;
    w = 0;
    while (!ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      check("ready_timeout", 32'(ready), 32'd1);
      n = -1;
      return;
    end
    start = 1'b1;
    op = o;
    dataA = a;
    dataB = b;
    addrD_in = ad;
    n = cyc + 1;
    @(posedge clk);
    e.d = ref_res(o, a, b);
    e.a = ad;
    e.w = ref_wen(o, ad);
    e.due = is_fast(o, a, b) ? n : n + 32;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom);
    dataA = $urandom;
    dataB = $urandom;
    addrD_in = 5'($urandom);
  endtask

  task automatic await_done(input string nm, input int n,
                            input logic [31:0] exp_d, input int exp_lat,
                            input logic exp_w);
    int w;
    w = 0;
    while (!done && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({nm, "_lat"}, 32'(cyc - n + 1), 32'(exp_lat));
    check({nm, "_d"}, dataD, exp_d);
    check({nm, "_w"}, 32'(RWen), 32'(exp_w));
    last_done = cyc;
  endtask

  task automatic run_direct(input string nm, input logic [2:0] o,
                            input logic [31:0] a, b, input logic [4:0] ad,
                            input logic [31:0] exp_d, input int exp_lat,
                            input logic exp_w);
    int n;
`ifndef MULDIV_DIV_EN
    if (o[2]) begin
      exp_d = 32'h0;
      exp_lat = 1;
      exp_w = 1'b0;
    end
`endif
    issue(o, a, b, ad, n);
    if (n < 0) return;
    await_done(nm, n, exp_d, exp_lat, exp_w);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, w;
    rst = 1'b1;
    start = 1'b0;
    op = 3'd0;
    dataA = 32'h0;
    dataB = 32'h0;
    addrD_in = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_RWen", 32'(RWen), 32'd0);
    check("rst_dataD", dataD, 32'h0);
    check("rst_addrD", 32'(addrD), 32'd0);
    chk_en = 1'b1;

    run_direct("mul_7x-3", MUL, 32'd7, 32'hFFFF_FFFD, 5'd5,
               32'hFFFF_FFEB, 33, 1'b1);
    check("mul_addrD", 32'(addrD), 32'd5);
    run_direct("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,
               32'hFFFF_FFFE, 33, 1'b1);
    run_direct("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,
               32'h0, 33, 1'b1);
    run_direct("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3,
               32'hFFFF_FFFF, 33, 1'b1);
    run_direct("div", DIV, 32'hFFFF_FFF9, 32'd2, 5'd4,
               32'hFFFF_FFFD, 33, 1'b1);
    run_direct("rem", REM, 32'hFFFF_FFF9, 32'd2, 5'd6,
               32'hFFFF_FFFF, 33, 1'b1);
    run_direct("divu", DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 33, 1'b1);
    run_direct("remu", REMU, 32'd100, 32'd7, 5'd8, 32'd2, 33, 1'b1);
    run_direct("divu0", DIVU, 32'd5, 32'd0, 5'd9,
               32'hFFFF_FFFF, 1, 1'b1);
    run_direct("rem0", REM, 32'd9, 32'd0, 5'd10, 32'd9, 1, 1'b1);
    run_direct("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11,
               32'h8000_0000, 1, 1'b1);
    run_direct("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12,
               32'h0, 1, 1'b1);
    run_direct("mul_x0", MUL, 32'd3, 32'd4, 5'd0, 32'd12, 33, 1'b0);
    t = last_done;
    run_direct("b2b", MUL, 32'd6, 32'd7, 5'd3, 32'd42, 33, 1'b1);
    check("b2b_gap", 32'(last_done - t), 32'd33);

    issue(MUL, 32'd5, 32'd6, 5'd13, n);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op = DIVU;
    dataA = 32'd77;
    dataB = 32'd0;
    addrD_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    await_done("busy_start", n, 32'd30, 33, 1'b1);

    issue(MUL, 32'd123, 32'd456, 5'd4, n);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_dataD", dataD, 32'h0);
    check("abort_addrD", 32'(addrD), 32'd0);
    repeat (40) @(negedge clk);

    rst = 1'b1;
    start = 1'b1;
    op = MUL;
    dataA = 32'd2;
    dataB = 32'd3;
    addrD_in = 5'd1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_done", 32'(done), 32'd0);

    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(),
            5'($urandom_range(0, 31)), n);
    end

    w = 0;
    while (q.size() > 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(q.size()), 32'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
